data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//  Shares the core's single data-memory port between two requesters: M0 = LSU, M1 = debug/DMA master.
//  Forwards one master's request per cycle downstream and tracks accepted transactions in an ID FIFO.
//  Routes in-order responses (rvalid/rdata) back to the issuing master. Sits between the LSU and the data RAM/bus.
// PARAMETERS
//  ADDR_W     32  address width
//  DATA_W     32  data width; BE width = DATA_W/8
//  MAX_OUTST   2  max accepted-but-unanswered transactions (ID FIFO depth, power of 2, >=1)
// PORTS
//  clk_i          in   1         clock
//  rst_i          in   1         asynchronous reset, active-high
//  m{0,1}_req_i   in   1         request, held until granted
//  m{0,1}_addr_i  in   ADDR_W    byte address
//  m{0,1}_we_i    in   1         1=store, 0=load
//  m{0,1}_be_i    in   DATA_W/8  byte enables
//  m{0,1}_wdata_i in   DATA_W    store data
//  m{0,1}_gnt_o   out  1         request accepted this cycle
//  m{0,1}_rvalid_o out 1         response valid for this master
//  m{0,1}_rdata_o out  DATA_W    load data (= data_rdata_i, qualified by rvalid)
//  data_req_o     out  1         downstream request
//  data_addr_o/data_we_o/data_be_o/data_wdata_o out  -  muxed from selected master
//  data_gnt_i     in   1         downstream grant
//  data_rvalid_i  in   1         downstream response valid (in order)
//  data_rdata_i   in   DATA_W    downstream read data
//  spurious_o     out  1         sticky: rvalid seen with ID FIFO empty
// BEHAVIOUR
//  - One clock, clk_i; reset is asynchronous and active-high (rst_i); all state cleared on rst_i rise.
//  - Reset values: FIFO empty, sel=M0, lock=0, spurious_o=0; all *_gnt_o/*_rvalid_o/data_req_o=0.
//  - Handshake: transfer when data_req_o & data_gnt_i; gnt passes through combinationally to selected master only.
//  - Stall: FIFO full -> data_req_o=0, no gnt to either master.
//  - Arbitration (FSM IDLE/LOCKED): IDLE: pick a requester per policy, drive data_req_o same cycle
//    (0-cycle added latency). No gnt -> go LOCKED on that master; addr/we/be/wdata/sel held until gnt
//    (the other master cannot steal). gnt -> push master ID, return to IDLE.
//  - Response: data_rvalid_i pops FIFO head; m<head>_rvalid_o=1 same cycle, other master's rvalid=0.
//  - Push and pop same cycle: both happen, occupancy unchanged; legal when full (pop frees slot, but
//    req is still blocked that cycle since full is a registered condition).
//  - Pointers wrap modulo MAX_OUTST; occupancy counter 0..MAX_OUTST.
//  - rvalid with FIFO empty: no master rvalid, spurious_o set until reset.
//  - Reset mid-transaction: outstanding IDs discarded; later rvalids count as spurious.
//  - Unselected master's rdata_o still equals data_rdata_i; masters qualify it with rvalid.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: round-robin; after a M0 grant M1 has priority, and vice versa
//    (last-granted register, reset to M1 so M0 wins first tie).
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, M0 (LSU) always wins ties; M1 may starve.
// TESTING
//  1 M0 load 0x100, gnt same cycle, rvalid +1 rdata=0xDEADBEEF -> m0_gnt_o=1 c0, m0_rvalid_o=1 c1 rdata 0xDEADBEEF, m1_rvalid_o=0.
//  2 M0+M1 request same cycle, gnt always 1 -> fixed: M0,M0.. while M0 req held; RR: M0,M1,M0,M1 grants.
//  3 M1 req addr 0x200, data_gnt_i low 3 cycles, M0 req from cycle 1 -> data_addr_o stays 0x200 until gnt, then M0 issued.
//  4 MAX_OUTST=2, 2 grants, no rvalid -> data_req_o=0 with req pending; rvalid -> resumes next cycle.
//  5 Interleaved M0,M1,M0 grants, 3 rvalids -> rvalid routed M0,M1,M0 in order, rdata 0x1,0x2,0x3.
//  6 rvalid with FIFO empty -> spurious_o=1 held; rst_i pulse mid-transaction -> all outputs 0, FIFO empty.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
//
// Shares the core's single data-memory port between two masters:
//   M0 = load/store unit, M1 = debug/DMA master.
// One request per cycle is forwarded downstream. The ID of every accepted
// transaction is written to a small in-order FIFO. Responses
// (data_rvalid_i/data_rdata_i) return in order, so each response is sent to
// the master whose ID is at the head of the FIFO.
//
// Handshake: a transfer happens in a cycle where data_req_o & data_gnt_i.
// A master holds its req (and its addr/we/be/wdata) until its gnt is seen.
// gnt reaches only the selected master, combinationally in the same cycle.
// While the FIFO is full, data_req_o is 0 and neither master gets a gnt.
//
// Optional feature (macro ARB_ROUND_ROBIN_EN):
//   defined   - round-robin arbitration. On a tie, the master that was NOT
//               granted last wins. The last-granted register resets to M1, so
//               M0 wins the first tie.
//   undefined - fixed priority. M0 always wins a tie; M1 may starve.
//
// Parameters:
//   ADDR_W     address width
//   DATA_W     data width (byte enables are DATA_W/8 bits)
//   MAX_OUTST  maximum accepted-but-unanswered transactions (FIFO depth,
//              a power of 2, >= 1)
//
// Ports:
//   clk_i, rst_i                  clock; asynchronous active-high reset
//   m{0,1}_req_i/addr_i/we_i/be_i/wdata_i   master request and its fields
//   m{0,1}_gnt_o                  request accepted this cycle
//   m{0,1}_rvalid_o               response valid for that master
//   m{0,1}_rdata_o                equal to data_rdata_i; valid only with rvalid
//   data_req_o/addr_o/we_o/be_o/wdata_o     downstream request
//   data_gnt_i                    downstream grant
//   data_rvalid_i, data_rdata_i   downstream in-order response
//   spurious_o                    sticky: rvalid arrived with the ID FIFO empty
//   arb_state_o                   debug: arbiter FSM state (0 = IDLE, 1 = LOCKED)
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // master 0 (LSU)
  input  logic                m0_req_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  // master 1 (debug / DMA)
  input  logic                m1_req_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  // downstream port
  output logic                data_req_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic                data_we_o,
  output logic [DATA_W/8-1:0] data_be_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  input  logic                data_gnt_i,
  input  logic                data_rvalid_i,
  input  logic [DATA_W-1:0]   data_rdata_i,
  // status / debug
  output logic                spurious_o,
  output logic                arb_state_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic                sel_q;        // master that is locked (0 = M0, 1 = M1)
  logic [ADDR_W-1:0]   hold_addr_q;
  logic                hold_we_q;
  logic [BE_W-1:0]     hold_be_q;
  logic [DATA_W-1:0]   hold_wdata_q;
  logic                spurious_q;

  // ID FIFO: one bit per entry holding the issuing master
  logic                id_mem_q [MAX_OUTST];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic                full;
  logic                empty;
  logic                pick;         // winner when the FSM is IDLE
  logic                sel;          // master currently driven downstream
  logic                capture;      // lock the request because gnt is low
  logic                push;
  logic                pop;
  logic                head_id;

  // Full and empty come only from the registered counter. A pop in the same
  // cycle therefore does not unblock a request until the next cycle.
  assign full  = (count_q == CNT_W'(MAX_OUTST));
  assign empty = (count_q == '0);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt_q;                  // master granted most recently

  always_comb begin
    if (m0_req_i && m1_req_i) begin
      pick = ~last_gnt_q;
    end else begin
      pick = m1_req_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_gnt_q <= 1'b1;            // M1, so that M0 wins the first tie
    end else if (push) begin
      last_gnt_q <= sel;
    end
  end
`else
  // Fixed priority: M0 wins whenever it is requesting.
  always_comb begin
    pick = ~m0_req_i;
  end
`endif

  // ---------------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sel        = sel_q;
    data_req_o = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        sel = pick;
        if (!full && (m0_req_i || m1_req_i)) begin
          data_req_o = 1'b1;
          if (!data_gnt_i) begin
            state_d = LOCKED;
            capture = 1'b1;
          end
        end
      end
      LOCKED: begin
        // The locked master keeps the port until it is granted. The other
        // master cannot take the port in the meantime.
        if (!full) begin
          data_req_o = 1'b1;
          if (data_gnt_i) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      hold_addr_q  <= '0;
      hold_we_q    <= 1'b0;
      hold_be_q    <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        sel_q        <= sel;
        hold_addr_q  <= sel ? m1_addr_i  : m0_addr_i;
        hold_we_q    <= sel ? m1_we_i    : m0_we_i;
        hold_be_q    <= sel ? m1_be_i    : m0_be_i;
        hold_wdata_q <= sel ? m1_wdata_i : m0_wdata_i;
      end
    end
  end

  assign arb_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Downstream request fields: the live mux when IDLE, the held copy when LOCKED
  // ---------------------------------------------------------------------------
  always_comb begin
    if (state_q == LOCKED) begin
      data_addr_o  = hold_addr_q;
      data_we_o    = hold_we_q;
      data_be_o    = hold_be_q;
      data_wdata_o = hold_wdata_q;
    end else begin
      data_addr_o  = sel ? m1_addr_i  : m0_addr_i;
      data_we_o    = sel ? m1_we_i    : m0_we_i;
      data_be_o    = sel ? m1_be_i    : m0_be_i;
      data_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    end
  end

  assign push     = data_req_o & data_gnt_i;
  assign m0_gnt_o = push & ~sel;
  assign m1_gnt_o = push &  sel;

  // ---------------------------------------------------------------------------
  // ID FIFO and response routing
  // ---------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTST - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign pop     = data_rvalid_i & ~empty;
  assign head_id = id_mem_q[rd_ptr_q];

  assign m0_rvalid_o = pop & ~head_id;
  assign m1_rvalid_o = pop &  head_id;
  assign m0_rdata_o  = data_rdata_i;
  assign m1_rdata_o  = data_rdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        id_mem_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        id_mem_q[wr_ptr_q] <= sel;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A response that arrives with no outstanding ID has no owner. It is dropped
  // and flagged until the next reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spurious_q <= 1'b0;
    end else if (data_rvalid_i && empty) begin
      spurious_q <= 1'b1;
    end
  end

  assign spurious_o = spurious_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_bus_arbiter
//
// Self-checking bench for data_bus_arbiter (default parameters). The same file
// also works with ARB_ROUND_ROBIN_EN defined: the expected arbitration outcome
// follows the macro.
// Contents: clock/reset block, driver tasks, a table of directed vectors,
// hand-written sequences for the spurious-response and reset corner cases,
// and a randomized phase checked against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_data_bus_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_OUTST = 2;
  localparam int N_RAND    = 600;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic              m_req   [2];
  logic [ADDR_W-1:0] m_addr  [2];
  logic              m_we    [2];
  logic [BE_W-1:0]   m_be    [2];
  logic [DATA_W-1:0] m_wdata [2];

  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              data_req, data_we, data_gnt, data_rvalid;
  logic [ADDR_W-1:0] data_addr;
  logic [BE_W-1:0]   data_be;
  logic [DATA_W-1:0] data_wdata, data_rdata;
  logic              spurious, arb_state;

  data_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m_req[0]), .m0_addr_i(m_addr[0]), .m0_we_i(m_we[0]),
    .m0_be_i(m_be[0]), .m0_wdata_i(m_wdata[0]),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m_req[1]), .m1_addr_i(m_addr[1]), .m1_we_i(m_we[1]),
    .m1_be_i(m_be[1]), .m1_wdata_i(m_wdata[1]),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .data_req_o(data_req), .data_addr_o(data_addr), .data_we_o(data_we),
    .data_be_o(data_be), .data_wdata_o(data_wdata),
    .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
    .spurious_o(spurious), .arb_state_o(arb_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model
  //   exp_q   : owners of the accepted, unanswered transactions, oldest first
  //   pend_*  : request that went out without gnt and is committed to the port
  //   last_m  : master granted most recently (round-robin tie-break)
  // ---------------------------------------------------------------------------
  logic [0:0]        exp_q[$];
  bit                pend_valid;
  int                pend_m;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_we;
  logic [BE_W-1:0]   pend_be;
  logic [DATA_W-1:0] pend_wdata;
  int                last_m;
  bit                spur;

  // expected outputs for the current cycle
  bit                e_req;
  int                e_sel;
  logic [ADDR_W-1:0] e_addr;
  logic              e_we;
  logic [BE_W-1:0]   e_be;
  logic [DATA_W-1:0] e_wdata;
  bit                e_gnt [2];
  bit                e_rv  [2];

  function automatic void model_reset();
    exp_q.delete();
    pend_valid = 0;
    pend_m     = 0;
    last_m     = 1;
    spur       = 0;
  endfunction

  function automatic void model_eval();
    e_req = 0; e_sel = 0; e_addr = '0; e_we = 0; e_be = '0; e_wdata = '0;
    e_gnt[0] = 0; e_gnt[1] = 0; e_rv[0] = 0; e_rv[1] = 0;
    if (exp_q.size() < MAX_OUTST) begin
      if (pend_valid) begin
        e_req = 1; e_sel = pend_m;
        e_addr = pend_addr; e_we = pend_we; e_be = pend_be; e_wdata = pend_wdata;
      end else if (m_req[0] || m_req[1]) begin
        e_req = 1;
        if (m_req[0] && m_req[1]) e_sel = RR_MODE ? 1 - last_m : 0;
        else                      e_sel = m_req[1] ? 1 : 0;
        e_addr = m_addr[e_sel]; e_we = m_we[e_sel];
        e_be = m_be[e_sel]; e_wdata = m_wdata[e_sel];
      end
    end
    if (e_req && data_gnt) e_gnt[e_sel] = 1;
    if (data_rvalid && exp_q.size() > 0) e_rv[exp_q[0]] = 1;
  endfunction

  function automatic void model_update();
    if (data_rvalid) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else                  spur = 1;
    end
    if (e_req && data_gnt) begin
      exp_q.push_back(e_sel[0]);
      pend_valid = 0;
      last_m     = e_sel;
    end else if (e_req) begin
      pend_valid = 1; pend_m = e_sel;
      pend_addr = e_addr; pend_we = e_we; pend_be = e_be; pend_wdata = e_wdata;
    end
  endfunction

  task automatic compare_model();
    check("req", data_req, e_req);
    check("m0_gnt", m0_gnt, e_gnt[0]);
    check("m1_gnt", m1_gnt, e_gnt[1]);
    check("m0_rvalid", m0_rvalid, e_rv[0]);
    check("m1_rvalid", m1_rvalid, e_rv[1]);
    check("m0_rdata", m0_rdata, data_rdata);
    check("m1_rdata", m1_rdata, data_rdata);
    check("spurious", spurious, spur);
    if (e_req) begin
      check("addr", data_addr, e_addr);
      check("we", data_we, e_we);
      check("be", data_be, e_be);
      check("wdata", data_wdata, e_wdata);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input bit r0, input logic [ADDR_W-1:0] a0,
                       input bit r1, input logic [ADDR_W-1:0] a1,
                       input bit g, input bit rv, input logic [DATA_W-1:0] rd);
    m_req[0] = r0; m_addr[0] = a0; m_we[0] = 1'b0; m_be[0] = 4'hF; m_wdata[0] = 32'h0;
    m_req[1] = r1; m_addr[1] = a1; m_we[1] = 1'b1; m_be[1] = 4'h3; m_wdata[1] = 32'h1111;
    data_gnt = g; data_rvalid = rv; data_rdata = rd;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, '0, 0, '0, 0, 0, '0);
    rst = 1'b1;
    #1;
    check("rst_req", data_req, 1'b0);
    check("rst_m0_gnt", m0_gnt, 1'b0);
    check("rst_m1_gnt", m1_gnt, 1'b0);
    check("rst_m0_rvalid", m0_rvalid, 1'b0);
    check("rst_m1_rvalid", m1_rvalid, 1'b0);
    check("rst_spurious", spurious, 1'b0);
    check("rst_state", arb_state, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit                r0;
    logic [ADDR_W-1:0] a0;
    bit                r1;
    logic [ADDR_W-1:0] a1;
    bit                gnt;
    bit                rv;
    logic [DATA_W-1:0] rdata;
    bit                x_req;
    logic [ADDR_W-1:0] x_addr;
    bit                x_g0, x_g1, x_rv0, x_rv1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r0, logic [ADDR_W-1:0] a0, bit r1, logic [ADDR_W-1:0] a1,
                              bit g, bit rv, logic [DATA_W-1:0] rd, bit x_req,
                              logic [ADDR_W-1:0] x_addr, bit x_g0, bit x_g1,
                              bit x_rv0, bit x_rv1);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.x_req = x_req; v.x_addr = x_addr;
    v.x_g0 = x_g0; v.x_g1 = x_g1; v.x_rv0 = x_rv0; v.x_rv1 = x_rv1;
    return v;
  endfunction

  function automatic void fill_table();
    // both masters requesting, gnt always 1, one response per cycle after the first
    tbl.push_back(mk(1,'h40,1,'h50,1,0,'h0,  1,'h40, 1,0, 0,0));
    tbl.push_back(mk(1,'h40,1,'h50,1,1,'hA1, 1, RR_MODE ? 'h50 : 'h40, !RR_MODE, RR_MODE, 1,0));
    tbl.push_back(mk(1,'h40,1,'h50,1,1,'hA2, 1,'h40, 1,0, !RR_MODE, RR_MODE));
    tbl.push_back(mk(1,'h40,1,'h50,1,1,'hA3, 1, RR_MODE ? 'h50 : 'h40, !RR_MODE, RR_MODE, 1,0));
    tbl.push_back(mk(0,'h0, 0,'h0, 0,1,'hA4, 0,'h0,  0,0, !RR_MODE, RR_MODE));
    // M0 load with immediate gnt, response one cycle later
    tbl.push_back(mk(1,'h100,0,'h0,1,0,'h0,         1,'h100, 1,0, 0,0));
    tbl.push_back(mk(0,'h0,  0,'h0,0,1,'hDEADBEEF,  0,'h0,   0,0, 1,0));
    // M1 locked for 3 cycles while M0 also requests
    tbl.push_back(mk(0,'h0,  1,'h200,0,0,'h0, 1,'h200, 0,0, 0,0));
    tbl.push_back(mk(1,'h300,1,'h200,0,0,'h0, 1,'h200, 0,0, 0,0));
    tbl.push_back(mk(1,'h300,1,'h200,0,0,'h0, 1,'h200, 0,0, 0,0));
    tbl.push_back(mk(1,'h300,1,'h200,1,0,'h0, 1,'h200, 0,1, 0,0));
    tbl.push_back(mk(1,'h300,0,'h0,  1,0,'h0, 1,'h300, 1,0, 0,0));
    // FIFO full: stall, pop while full still stalls, resume next cycle
    tbl.push_back(mk(1,'h304,0,'h0,1,0,'h0, 0,'h0,   0,0, 0,0));
    tbl.push_back(mk(1,'h304,0,'h0,1,1,'h2, 0,'h0,   0,0, 0,1));
    tbl.push_back(mk(1,'h304,0,'h0,1,1,'h1, 1,'h304, 1,0, 1,0));
    tbl.push_back(mk(0,'h0,  0,'h0,0,1,'h3, 0,'h0,   0,0, 1,0));
    // interleaved M0,M1,M0 with in-order responses 1,2,3
    tbl.push_back(mk(1,'h10,0,'h0, 1,0,'h0, 1,'h10, 1,0, 0,0));
    tbl.push_back(mk(0,'h0, 1,'h20,1,0,'h0, 1,'h20, 0,1, 0,0));
    tbl.push_back(mk(0,'h0, 0,'h0, 0,1,'h1, 0,'h0,  0,0, 1,0));
    tbl.push_back(mk(1,'h30,0,'h0, 1,1,'h2, 1,'h30, 1,0, 0,1));
    tbl.push_back(mk(0,'h0, 0,'h0, 0,1,'h3, 0,'h0,  0,0, 1,0));
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_req[k] = 0; m_addr[k] = '0; m_we[k] = 0; m_be[k] = '0; m_wdata[k] = '0;
    end
    data_gnt = 0; data_rvalid = 0; data_rdata = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // table-driven vectors
    fill_table();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      check($sformatf("v%0d_req", i), data_req, tbl[i].x_req);
      check($sformatf("v%0d_m0_gnt", i), m0_gnt, tbl[i].x_g0);
      check($sformatf("v%0d_m1_gnt", i), m1_gnt, tbl[i].x_g1);
      check($sformatf("v%0d_m0_rvalid", i), m0_rvalid, tbl[i].x_rv0);
      check($sformatf("v%0d_m1_rvalid", i), m1_rvalid, tbl[i].x_rv1);
      check($sformatf("v%0d_m0_rdata", i), m0_rdata, tbl[i].rdata);
      check($sformatf("v%0d_m1_rdata", i), m1_rdata, tbl[i].rdata);
      if (tbl[i].x_req) check($sformatf("v%0d_addr", i), data_addr, tbl[i].x_addr);
      tick();
    end
    check("tbl_spurious", spurious, 1'b0);

    // spurious response: no owner, flag stays set
    drive(0, '0, 0, '0, 0, 1, 32'h55);
    check("spur_m0_rvalid", m0_rvalid, 1'b0);
    check("spur_m1_rvalid", m1_rvalid, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 0, '0, 0, 0, '0);
      check("spur_sticky", spurious, 1'b1);
      tick();
    end

    // reset with one ID outstanding and M1 locked
    drive(1, 'h400, 0, '0, 1, 0, '0);
    check("pre_rst_m0_gnt", m0_gnt, 1'b1);
    tick();
    drive(0, '0, 1, 'h500, 0, 0, '0);
    check("pre_rst_addr", data_addr, 32'h500);
    tick();
    check("pre_rst_state", arb_state, 1'b1);
    do_reset();
    drive(0, '0, 0, '0, 0, 1, 32'h66);
    check("post_rst_m0_rvalid", m0_rvalid, 1'b0);
    check("post_rst_m1_rvalid", m1_rvalid, 1'b0);
    tick();
    drive(0, '0, 0, '0, 0, 0, '0);
    check("post_rst_spurious", spurious, 1'b1);
    do_reset();

    // randomized traffic against the model
    for (int c = 0; c < N_RAND; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_req[k] && $urandom_range(0, 1) == 1) begin
          m_req[k]   = 1'b1;
          m_addr[k]  = $urandom();
          m_we[k]    = 1'($urandom_range(0, 1));
          m_be[k]    = 4'($urandom_range(0, 15));
          m_wdata[k] = $urandom();
        end
      end
      data_gnt    = ($urandom_range(0, 3) != 0);
      data_rvalid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      data_rdata  = $urandom();
      #1;
      model_eval();
      compare_model();
      tick();
      for (int k = 0; k < 2; k++) begin
        if (e_gnt[k]) m_req[k] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
